// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command transmitter: FSM states, line levels, data width.
package uart_cmd_pkg;

  // Payload width of one command byte (control nibble + value nibble)
  localparam int DATA_W = 8;
  localparam int BIT_IDX_W = $clog2(DATA_W);

  // Serial line levels
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Transmitter states; ST_PARITY is only entered when parity generation is built in
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read: rd_data always presents the oldest entry,
// so the transmitter can pop and load its shift register on the same edge.
module uart_cmd_fifo
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign wr_addr = wr_ptr_reg[AW-1:0];
  assign rd_addr = rd_ptr_reg[AW-1:0];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_addr == rd_addr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_addr];

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Pointer update; both wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// UART command transmitter: queues {ctrl, value} nibble pairs in a FIFO and sends each
// as an 8N1 frame (start, 8 data bits LSB first, stop).
// Optional build macro UART_CMD_TX_PARITY_EN inserts an even-parity bit after bit 7.
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ctrl_command_in,
  input  logic [3:0] value_command_in,
  input  logic       command_in_flag,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_W - 1);

  tx_state_t            state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [BIT_IDX_W-1:0] bit_idx_reg;
  logic [BIT_IDX_W-1:0] bit_idx_next;
  logic [DATA_W-1:0]    frame_byte_reg;
  logic                 uart_tx_reg;
  logic                 overflow_reg;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [DATA_W-1:0]    fifo_rd_data;
  logic                 bit_end;

  // A command is accepted only when there is room; reset cycles never enqueue
  assign fifo_push    = command_in_flag && !fifo_full && !rst;
  // Pop happens exactly on the edge that leaves IDLE
  assign fifo_pop     = (state_reg == ST_IDLE) && !fifo_empty && !rst;
  assign bit_end      = (cnt_reg == CNT_LAST);
  assign bit_idx_next = bit_idx_reg + BIT_IDX_W'(1);

  assign uart_tx  = uart_tx_reg;
  assign overflow = overflow_reg;
  assign tx_busy  = (state_reg != ST_IDLE) || !fifo_empty;

  uart_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({ctrl_command_in, value_command_in}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencer: each state holds its line level for BAUD_DIV cycles; the line
  // level is registered and changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      frame_byte_reg <= '0;
      uart_tx_reg    <= IDLE_LVL;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          uart_tx_reg <= IDLE_LVL;
          if (!fifo_empty) begin
            frame_byte_reg <= fifo_rd_data;
            uart_tx_reg    <= START_LVL;
            state_reg      <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            cnt_reg     <= '0;
            uart_tx_reg <= frame_byte_reg[0];
            state_reg   <= ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (bit_idx_reg == BIT_LAST) begin
`ifdef UART_CMD_TX_PARITY_EN
              // Even parity: the parity bit makes the total count of ones even
              uart_tx_reg <= ^frame_byte_reg;
              state_reg   <= ST_PARITY;
`else
              uart_tx_reg <= STOP_LVL;
              state_reg   <= ST_STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_next;
              uart_tx_reg <= frame_byte_reg[bit_idx_next];
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

`ifdef UART_CMD_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            cnt_reg     <= '0;
            uart_tx_reg <= STOP_LVL;
            state_reg   <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            cnt_reg     <= '0;
            uart_tx_reg <= IDLE_LVL;
            state_reg   <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          cnt_reg     <= '0;
          uart_tx_reg <= IDLE_LVL;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky drop indicator: a command arriving while full is lost even if a pop frees space this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (command_in_flag && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Self-checking bench for uart_cmd_tx: table of single frames, hand-written corner
// sequences, and random commands, all checked cycle by cycle against a queue/time model.
module tb_uart_cmd_tx;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD_RATE = 115200;
  localparam int DEPTH     = 8;
  localparam int BD        = CLK_FREQ / BAUD_RATE;
`ifdef UART_CMD_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ctrl = 4'h0;
  logic [3:0] value = 4'h0;
  logic       flag = 1'b0;
  logic       uart_tx, tx_busy, fifo_full, overflow;

  always #5 clk = ~clk;

  uart_cmd_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ctrl_command_in  (ctrl),
    .value_command_in (value),
    .command_in_flag  (flag),
    .uart_tx          (uart_tx),
    .tx_busy          (tx_busy),
    .fifo_full        (fifo_full),
    .overflow         (overflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a queue of pending bytes plus the elapsed time of the frame on the line
  logic [7:0] m_q[$];
  bit         m_active = 0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 0;

  // Per-cycle comparison accumulator
  int    win_err = 0;
  string win_msg = "";

  // Line decoder: samples mid-bit and collects received bytes with start timestamps
  bit         d_on = 0;
  int         d_cnt = 0;
  logic [7:0] d_byte = 8'h00;
  logic [7:0] d_rx[$];
  int         d_start[$];

  // Expected line level from frame-relative time
  function automatic logic exp_line();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / BD;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef UART_CMD_TX_PARITY_EN
    if (b == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic note_err(input string msg);
    if (win_err == 0) win_msg = msg;
    win_err++;
  endtask

  task automatic tick();
    bit   full_pre;
    logic e_tx, e_busy, e_full;
    int   k;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_q.delete();
      m_active = 0;
      m_t = 0;
      m_ovf = 0;
    end else begin
      full_pre = (m_q.size() == DEPTH);
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) m_active = 0;
      end else if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_active = 1;
        m_t = 0;
        $display("cycle %0d: frame start byte=%02h", cyc, m_cur);
      end
      if (flag) begin
        if (full_pre) m_ovf = 1;
        else m_q.push_back({ctrl, value});
      end
    end
    #1;
    e_tx   = exp_line();
    e_busy = m_active || (m_q.size() > 0);
    e_full = (m_q.size() == DEPTH);
    if ({uart_tx, tx_busy, fifo_full, overflow} !== {e_tx, e_busy, e_full, m_ovf})
      note_err($sformatf("cycle %0d tx/busy/full/ovf got %b%b%b%b want %b%b%b%b", cyc,
                         uart_tx, tx_busy, fifo_full, overflow, e_tx, e_busy, e_full, m_ovf));
    if (rst) begin
      d_on = 0;
    end else if (!d_on) begin
      if (uart_tx == 1'b0) begin
        d_on = 1;
        d_cnt = 0;
        d_byte = 8'h00;
        d_start.push_back(cyc);
      end
    end else begin
      d_cnt++;
      if (d_cnt % BD == BD / 2) begin
        k = d_cnt / BD;
        if (k == 0 && uart_tx !== 1'b0) note_err($sformatf("cycle %0d bad start bit", cyc));
        if (k >= 1 && k <= 8) d_byte[k-1] = uart_tx;
`ifdef UART_CMD_TX_PARITY_EN
        if (k == 9 && uart_tx !== ^d_byte) note_err($sformatf("cycle %0d bad parity bit", cyc));
`endif
        if (k == NB - 1) begin
          if (uart_tx !== 1'b1) note_err($sformatf("cycle %0d bad stop bit", cyc));
          d_rx.push_back(d_byte);
          $display("cycle %0d: frame received byte=%02h", cyc, d_byte);
          d_on = 0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic check_window(input string name);
    total++;
    if (win_err != 0) begin
      bad++;
      $display("FAIL %s: %0d model differences, first: %s", name, win_err, win_msg);
    end
    win_err = 0;
  endtask

  task automatic drive(input logic [7:0] b);
    ctrl  = b[7:4];
    value = b[3:0];
    flag  = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b);
    tick();
    flag = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (tx_busy && n < bound) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, int'(tx_busy), 0);
  endtask

  task automatic clear_logs();
    d_rx.delete();
    d_start.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // line levels, first-sent in bit 9, without parity
    logic       par;   // expected even-parity bit
  } vec_t;

  vec_t vecs[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] cap;
    logic [10:0] want;
    int          t0;
    logic [7:0]  issued[$];
    bit          saw_full;

    vecs[0] = '{data: 8'h3A, seq: 10'b0010111001, par: 1'b0};
    vecs[1] = '{data: 8'h07, seq: 10'b0111000001, par: 1'b1};
    vecs[2] = '{data: 8'h80, seq: 10'b0000000011, par: 1'b1};

    // Reset state, with a flag raised during reset that must be ignored
    rst = 1'b1;
    drive(8'hC3);
    run(3);
    flag = 1'b0;
    check("rst_uart_tx", int'(uart_tx), 1);
    check("rst_tx_busy", int'(tx_busy), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    run(5);
    check("rst_flag_ignored_busy", int'(tx_busy), 0);
    check_window("reset_phase");

    // Table of single frames: latency, bit sequence and busy duration
    foreach (vecs[i]) begin
      clear_logs();
      send(vecs[i].data);
      check($sformatf("row%0d_line_high_after_first_edge", i), int'(uart_tx), 1);
      tick();
      check($sformatf("row%0d_line_low_second_edge", i), int'(uart_tx), 0);
      t0 = cyc;
      cap = '0;
      run(BD / 2);
      for (int k = 0; k < NB; k++) begin
        cap = {cap[9:0], uart_tx};
        if (k < NB - 1) run(BD);
      end
`ifdef UART_CMD_TX_PARITY_EN
      want = {vecs[i].seq[9:1], vecs[i].par, vecs[i].seq[0]};
`else
      want = {1'b0, vecs[i].seq};
`endif
      check($sformatf("row%0d_bit_sequence", i), int'(cap), int'(want));
      wait_idle($sformatf("row%0d", i), FRAME);
      check($sformatf("row%0d_busy_cycles", i), cyc - t0, FRAME);
      run(3);
      check_window($sformatf("row%0d_model", i));
    end

    // Back-to-back commands on consecutive cycles
    clear_logs();
    drive(8'h11); tick();
    drive(8'h22); tick();
    drive(8'h33); tick();
    flag = 1'b0;
    wait_idle("b2b", 3 * FRAME + 50);
    run(BD);
    check("b2b_frame_count", d_rx.size(), 3);
    if (d_rx.size() == 3) begin
      check("b2b_byte0", int'(d_rx[0]), 'h11);
      check("b2b_byte1", int'(d_rx[1]), 'h22);
      check("b2b_byte2", int'(d_rx[2]), 'h33);
      check("b2b_gap01", d_start[1] - d_start[0], FRAME + 1);
      check("b2b_gap12", d_start[2] - d_start[1], FRAME + 1);
    end
    check_window("b2b_model");

    // Overflow: ten consecutive commands into an eight-entry queue
    clear_logs();
    saw_full = 0;
    for (int i = 0; i < 10; i++) begin
      drive(8'(i));
      tick();
      if (fifo_full) saw_full = 1;
    end
    flag = 1'b0;
    check("ovf_flag", int'(overflow), 1);
    check("ovf_full_seen", int'(saw_full), 1);
    wait_idle("ovf", 9 * FRAME + 100);
    run(BD);
    check("ovf_frame_count", d_rx.size(), 9);
    for (int i = 0; i < d_rx.size() && i < 9; i++)
      check($sformatf("ovf_byte%0d", i), int'(d_rx[i]), i);
    check("ovf_still_sticky", int'(overflow), 1);
    check_window("ovf_model");

    // Reset during data bit 4, with a flag presented in the reset cycle
    clear_logs();
    send(8'hA5);
    tick();
    run(5 * BD + 100);
    rst = 1'b1;
    drive(8'hEE);
    tick();
    rst = 1'b0;
    flag = 1'b0;
    check("midrst_uart_tx", int'(uart_tx), 1);
    check("midrst_tx_busy", int'(tx_busy), 0);
    check("midrst_overflow", int'(overflow), 0);
    check("midrst_fifo_full", int'(fifo_full), 0);
    run(2 * BD);
    check("midrst_no_frame", d_rx.size(), 0);
    send(8'h55);
    wait_idle("midrst_follow", FRAME + 10);
    run(BD);
    check("midrst_follow_count", d_rx.size(), 1);
    if (d_rx.size() == 1) check("midrst_follow_byte", int'(d_rx[0]), 'h55);
    check_window("midrst_model");

    // Random commands with random spacing, some landing mid-frame
    clear_logs();
    for (int j = 0; j < 3; j++) begin
      logic [7:0] b;
      run($urandom_range(0, 2000));
      b = 8'($urandom);
      issued.push_back(b);
      send(b);
    end
    wait_idle("rand", 3 * FRAME + 100);
    run(BD);
    check("rand_frame_count", d_rx.size(), issued.size());
    for (int i = 0; i < d_rx.size() && i < issued.size(); i++)
      check($sformatf("rand_byte%0d", i), int'(d_rx[i]), int'(issued[i]));
    check_window("rand_model");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
